// File: rtl/mul_div_pkg.sv
// mul_div_pkg: operation and state encodings shared by the multiply/divide unit and its bench.
package mul_div_pkg;
  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULU = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [1:0] OP_DIVU = 2'b11;
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;
endpackage

// File: rtl/mul_div_if.sv
// mul_div_if: start/busy/done handshake, operands and results between the Y/bus path and the unit.
interface mul_div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             abort;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_hi;
  logic [WIDTH-1:0] result_lo;
  logic             div_by_zero;
  modport master (output start, abort, op, a, b, input busy, done, result_hi, result_lo, div_by_zero);
  modport slave  (input start, abort, op, a, b, output busy, done, result_hi, result_lo, div_by_zero);
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: radix-2 multi-cycle signed/unsigned multiply and restoring divide on magnitudes.
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clock,
  input  logic     clear_n,
  mul_div_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  state_t state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [WIDTH-1:0] am_q, am_d, bm_q, bm_d, hi_q, hi_d, lo_q, lo_d;
  logic sa_q, sa_d, sb_q, sb_d, zero_q, zero_d, dbz_q, dbz_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic in_signed, in_sa, in_sb, is_signed, is_div, neg_q, div_ge;
  logic [WIDTH-1:0] in_am, in_bm, a_raw, quo, rem, div_diff;
  logic [WIDTH:0] mul_sum, div_sh;
  logic [2*WIDTH-1:0] mul_step, div_step, prod;
  assign in_signed = ~bus.op[0];
  assign in_sa = in_signed & bus.a[WIDTH-1];
  assign in_sb = in_signed & bus.b[WIDTH-1];
  assign in_am = in_sa ? -bus.a : bus.a;
  assign in_bm = in_sb ? -bus.b : bus.b;
  assign is_signed = ~op_q[0];
  assign is_div = op_q[1];
  assign neg_q = is_signed & (sa_q ^ sb_q);
  // Multiply: {acc_hi, multiplier} shifts right, adding |a| into the top half on a set LSB.
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, acc_q[0] ? am_q : '0};
  assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};
  // Divide: {remainder, dividend} shifts left; guard bit keeps the trial subtract exact.
  assign div_sh = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_ge = div_sh >= {1'b0, bm_q};
  assign div_diff = div_sh[WIDTH-1:0] - bm_q;
  assign div_step = {div_ge ? div_diff : div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], div_ge};
  assign prod = neg_q ? -acc_q : acc_q;
  assign a_raw = sa_q ? -am_q : am_q;
  assign quo = zero_q ? '1 : neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem = zero_q ? a_raw : (is_signed & sa_q) ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    am_d = am_q;
    bm_d = bm_q;
    sa_d = sa_q;
    sb_d = sb_q;
    zero_d = zero_q;
    dbz_d = dbz_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    hi_d = hi_q;
    lo_d = lo_q;
    case (state_q)
      IDLE: if (bus.start && !bus.abort) begin
        op_d = bus.op;
        am_d = in_am;
        bm_d = in_bm;
        sa_d = in_sa;
        sb_d = in_sb;
        cnt_d = CNT_W'(WIDTH);
        zero_d = bus.op[1] && bus.b == '0;
        dbz_d = 1'b0;
        acc_d = {{WIDTH{1'b0}}, bus.op[1] ? in_am : in_bm};
        state_d = (bus.op[1] && bus.b == '0) ? FIX : CALC;
      end
      CALC: begin
        acc_d = is_div ? div_step : mul_step;
        cnt_d = cnt_q - CNT_W'(1);
        state_d = bus.abort ? IDLE : (cnt_q == CNT_W'(1)) ? FIX : CALC;
      end
      FIX: if (bus.abort) state_d = IDLE;
      else begin
        hi_d = is_div ? rem : prod[2*WIDTH-1:WIDTH];
        lo_d = is_div ? quo : prod[WIDTH-1:0];
        dbz_d = zero_q;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      op_q <= '0;
      am_q <= '0;
      bm_q <= '0;
      sa_q <= 1'b0;
      sb_q <= 1'b0;
      zero_q <= 1'b0;
      dbz_q <= 1'b0;
      cnt_q <= '0;
      acc_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      am_q <= am_d;
      bm_q <= bm_d;
      sa_q <= sa_d;
      sb_q <= sb_d;
      zero_q <= zero_d;
      dbz_q <= dbz_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end
  assign bus.busy = state_q == CALC || state_q == FIX;
  assign bus.done = state_q == DONE;
  assign bus.result_hi = hi_q;
  assign bus.result_lo = lo_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: vector table, randomized ops against an arithmetic model, and control corner cases.
module tb_mul_div_unit;
  import mul_div_pkg::*;
  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dz;
  } vec_t;
  logic clock = 1'b0;
  logic clear_n = 1'b0;
  int passed = 0;
  int total = 0;
  logic [31:0] prev_hi = '0, prev_lo = '0;
  vec_t vecs[11];
  mul_div_if #(.WIDTH(32)) ifc();
  mul_div_unit #(.WIDTH(32)) dut (.clock(clock), .clear_n(clear_n), .bus(ifc.slave));
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    longint x, y;
    logic [63:0] p;
    int sq, sr;
    dz = 1'b0;
    hi = '0;
    lo = '0;
    if (op == OP_MUL) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
      p = 64'(x * y);
      {hi, lo} = p;
    end else if (op == OP_MULU) begin
      p = {32'b0, a} * {32'b0, b};
      {hi, lo} = p;
    end else if (b == 0) begin
      dz = 1'b1;
      lo = '1;
      hi = a;
    end else if (op == OP_DIVU) begin
      lo = a / b;
      hi = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      lo = a;
      hi = '0;
    end else begin
      sq = $signed(a) / $signed(b);
      sr = $signed(a) % $signed(b);
      lo = sq;
      hi = sr;
    end
  endfunction
  // Issues one op, then watches a fixed 40-cycle window; poke re-asserts start, abrt pulses abort (0 = with start).
  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int poke, input int abrt,
                     output int first, output int dones, output int busy_n,
                     output logic [31:0] hi, output logic [31:0] lo, output logic dz,
                     output logic [31:0] e_hi, output logic [31:0] e_lo, output logic e_dz);
    @(negedge clock);
    ifc.op = op;
    ifc.a = a;
    ifc.b = b;
    ifc.start = 1'b1;
    ifc.abort = (abrt == 0);
    first = 0;
    dones = 0;
    busy_n = 0;
    hi = '0;
    lo = '0;
    dz = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      ifc.start = (c == poke);
      ifc.abort = (c == abrt);
      if (c == 1 || c == poke) begin
        ifc.op = 2'($urandom);
        ifc.a = $urandom;
        ifc.b = $urandom;
      end
      busy_n += int'(ifc.busy);
      if (ifc.done) begin
        dones++;
        if (first == 0) begin
          first = c;
          hi = ifc.result_hi;
          lo = ifc.result_lo;
          dz = ifc.div_by_zero;
        end
      end
    end
    e_hi = ifc.result_hi;
    e_lo = ifc.result_lo;
    e_dz = ifc.div_by_zero;
  endtask
  task automatic full(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] xhi, input logic [31:0] xlo, input logic xdz, input bit detail);
    int first, dones, busy_n;
    logic [31:0] hi, lo, e_hi, e_lo;
    logic dz, e_dz;
    int lat;
    lat = (op[1] && b == 0) ? 2 : 34;
    run(op, a, b, -1, -1, first, dones, busy_n, hi, lo, dz, e_hi, e_lo, e_dz);
    chk({tag, " result"}, {hi, lo}, {xhi, xlo});
    chk({tag, " dz"}, 64'(dz), 64'(xdz));
    if (detail) begin
      chk({tag, " latency"}, 64'(first), 64'(lat));
      chk({tag, " busy cycles"}, 64'(busy_n), 64'(lat - 1));
      chk({tag, " done pulses"}, 64'(dones), 64'd1);
      chk({tag, " dz held"}, 64'(e_dz), 64'(xdz));
    end
    prev_hi = xhi;
    prev_lo = xlo;
  endtask
  initial begin
    int first, dones, busy_n;
    logic [31:0] hi, lo, e_hi, e_lo, xhi, xlo, ra, rb;
    logic dz, e_dz, xdz;
    logic [1:0] rop;
    vecs[0]  = '{OP_MUL,  32'hFFFF_FFF9, 32'd6,        32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0};
    vecs[1]  = '{OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[2]  = '{OP_DIV,  32'hFFFF_FFEF, 32'd5,        32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0};
    vecs[3]  = '{OP_DIVU, 32'd17,        32'd5,        32'd2,         32'd3,         1'b0};
    vecs[4]  = '{OP_DIV,  32'h0000_1234, 32'd0,        32'h0000_1234, 32'hFFFF_FFFF, 1'b1};
    vecs[5]  = '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000, 1'b0};
    vecs[6]  = '{OP_DIVU, 32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF, 1'b1};
    vecs[7]  = '{OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 1'b0};
    vecs[8]  = '{OP_MUL,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,        1'b0};
    vecs[9]  = '{OP_MULU, 32'd0,         32'h1234_5678, 32'h0,        32'h0,         1'b0};
    vecs[10] = '{OP_DIV,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3,        1'b0};
    ifc.start = 1'b0;
    ifc.abort = 1'b0;
    ifc.op = '0;
    ifc.a = '0;
    ifc.b = '0;
    repeat (3) @(negedge clock);
    chk("reset outputs", {29'b0, ifc.busy, ifc.done, ifc.div_by_zero, ifc.result_hi}, 64'd0);
    chk("reset lo", 64'(ifc.result_lo), 64'd0);
    clear_n = 1'b1;
    for (int i = 0; i < 11; i++)
      full($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dz, 1'b1);
    for (int i = 0; i < 150; i++) begin
      rop = 2'($urandom);
      ra = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'($urandom_range(0, 3)) : $urandom >> $urandom_range(0, 31);
      model(rop, ra, rb, xhi, xlo, xdz);
      full($sformatf("rnd%0d op%0d %h/%h", i, rop, ra, rb), rop, ra, rb, xhi, xlo, xdz, i < 8);
    end
    run(OP_MULU, 32'd3, 32'd5, 5, -1, first, dones, busy_n, hi, lo, dz, e_hi, e_lo, e_dz);
    chk("busy start ignored result", {hi, lo}, 64'd15);
    chk("busy start ignored dones", 64'(dones), 64'd1);
    chk("busy start ignored latency", 64'(first), 64'd34);
    chk("busy start ignored end", {e_hi, e_lo}, 64'd15);
    run(OP_MUL, 32'd99, 32'd77, -1, 10, first, dones, busy_n, hi, lo, dz, e_hi, e_lo, e_dz);
    chk("abort no done", 64'(dones), 64'd0);
    chk("abort busy cycles", 64'(busy_n), 64'd10);
    chk("abort results held", {e_hi, e_lo}, 64'd15);
    run(OP_DIVU, 32'd50, 32'd0, -1, 0, first, dones, busy_n, hi, lo, dz, e_hi, e_lo, e_dz);
    chk("abort blocks start dones", 64'(dones), 64'd0);
    chk("abort blocks start busy", 64'(busy_n), 64'd0);
    chk("abort blocks start held", {31'b0, e_dz, e_lo}, 64'd15);
    @(negedge clock);
    ifc.op = OP_MULU;
    ifc.a = 32'd1000;
    ifc.b = 32'd1000;
    ifc.start = 1'b1;
    @(negedge clock);
    ifc.start = 1'b0;
    repeat (9) @(negedge clock);
    chk("busy before reset", 64'(ifc.busy), 64'd1);
    clear_n = 1'b0;
    #1;
    chk("async reset flags", {61'b0, ifc.busy, ifc.done, ifc.div_by_zero}, 64'd0);
    chk("async reset results", {ifc.result_hi, ifc.result_lo}, 64'd0);
    @(negedge clock);
    clear_n = 1'b1;
    full("after reset", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
